// File: rtl/pcie_rx_bridge_ptile.sv
// P-tile HIP Avalon-ST RX to AXI4-S RX bridge.
// The skid FIFO soaks up beats the HIP sends during its ready latency. The AXI4-S
// head is a registered show-ahead stage. A CplD header tap on the input side
// retires outstanding read credit.
module pcie_rx_bridge_ptile #(
   parameter int RL    = 3,
   parameter int DEPTH = 16,
   parameter int TAG_W = 8
) (
   input  logic               avl_clk,
   input  logic               avl_rst,
   input  logic [1:0]         avl_rx_valid,
   input  logic [1:0]         avl_rx_sop,
   input  logic [1:0]         avl_rx_eop,
   input  logic [255:0]       avl_rx_hdr,
   input  logic [511:0]       avl_rx_data,
   output logic               avl_rx_ready,
   output logic               axis_rx_tvalid,
   input  logic               axis_rx_tready,
   output logic [511:0]       axis_rx_tdata,
   output logic [261:0]       axis_rx_tuser,
   output logic [1:0]         rx_cpl_valid,
   output logic [21:0]        rx_cpl_length,
   output logic [2*TAG_W-1:0] rx_cpl_tag,
   output logic               rx_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 512 + 262;

   // The output register counts toward occupancy, so the bridge holds DEPTH beats
   // in total: up to DEPTH-1 in the array and one in the head stage.
   logic [EW-1:0]      mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d, occ, occ_d;
   logic               out_valid_q, out_valid_d;
   logic [EW-1:0]      out_q, out_d;
   logic               ready_q, ready_d;
   logic               overflow_q;
   logic               pop, push, push_ok, mem_we, mem_re;
   logic [EW-1:0]      in_entry;
   logic [1:0]         cpl_match;
   logic [21:0]        cpl_len_d, cpl_len_q;
   logic [2*TAG_W-1:0] cpl_tag_d, cpl_tag_q;
   logic [1:0]         cpl_valid_q;

   assign in_entry = {avl_rx_data,
                      avl_rx_valid[1], avl_rx_sop[1], avl_rx_eop[1], avl_rx_hdr[255:128],
                      avl_rx_valid[0], avl_rx_sop[0], avl_rx_eop[0], avl_rx_hdr[127:0]};

   // FIFO control: the head stage refills from the array first, and takes the
   // input directly when the array is empty.
   always_comb begin
      pop         = out_valid_q & axis_rx_tready;
      occ         = fifo_cnt_q + CW'(out_valid_q);
      push        = |avl_rx_valid;
      push_ok     = push && (occ != CW'(DEPTH));
      out_d       = out_q;
      out_valid_d = out_valid_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      if (!out_valid_q || pop) begin
         if (fifo_cnt_q != '0) begin
            out_d       = mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
            mem_re      = 1'b1;
            rd_ptr_d    = rd_ptr_q + AW'(1);
            mem_we      = push_ok;
         end else if (push_ok) begin
            out_d       = in_entry;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         mem_we = push_ok;
      end
      if (mem_we) wr_ptr_d = wr_ptr_q + AW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(mem_we) - CW'(mem_re);
      occ_d      = fifo_cnt_d + CW'(out_valid_d);
      ready_d    = (occ_d <= CW'(DEPTH - RL - 2));
   end

   // CplD header decode per channel.
   always_comb begin
      cpl_match = '0;
      cpl_len_d = '0;
      cpl_tag_d = '0;
      for (int c = 0; c < 2; c++) begin
         cpl_match[c] = avl_rx_valid[c] & avl_rx_sop[c]
                        & (avl_rx_hdr[c*128+29 +: 3] == 3'b010)
                        & (avl_rx_hdr[c*128+24 +: 5] == 5'b01010);
         cpl_len_d[c*11 +: 11] = (avl_rx_hdr[c*128 +: 10] == 10'd0) ? 11'd1024
                                 : {1'b0, avl_rx_hdr[c*128 +: 10]};
         cpl_tag_d[c*TAG_W +: TAG_W] = avl_rx_hdr[c*128+72 +: TAG_W];
      end
   end

   // Storage array. It needs no reset because only occupied entries are ever read.
   always_ff @(posedge avl_clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= in_entry;
   end

   // Pointers, head stage, ready, overflow and tap registers.
   always_ff @(posedge avl_clk or posedge avl_rst) begin
      if (avl_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ready_q     <= 1'b0;
         overflow_q  <= 1'b0;
         cpl_valid_q <= '0;
         cpl_len_q   <= '0;
         cpl_tag_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         ready_q     <= ready_d;
         if (push && !push_ok) overflow_q <= 1'b1;
         cpl_valid_q <= cpl_match;
         for (int c = 0; c < 2; c++) begin
            if (cpl_match[c]) begin
               cpl_len_q[c*11 +: 11]       <= cpl_len_d[c*11 +: 11];
               cpl_tag_q[c*TAG_W +: TAG_W] <= cpl_tag_d[c*TAG_W +: TAG_W];
            end
         end
      end
   end

   assign avl_rx_ready   = ready_q;
   assign axis_rx_tvalid = out_valid_q;
   assign axis_rx_tdata  = out_q[EW-1:262];
   assign axis_rx_tuser  = out_q[261:0];
   assign rx_cpl_valid   = cpl_valid_q;
   assign rx_cpl_length  = cpl_len_q;
   assign rx_cpl_tag     = cpl_tag_q;
   assign rx_overflow    = overflow_q;

endmodule

// File: tb/tb_pcie_rx_bridge_ptile.sv
// Bench for pcie_rx_bridge_ptile: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_pcie_rx_bridge_ptile;

   localparam int RL    = 3;
   localparam int DEPTH = 16;
   localparam int TAG_W = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    i_valid = '0, i_sop = '0, i_eop = '0;
   logic [255:0]  i_hdr = '0;
   logic [511:0]  i_data = '0;
   logic          o_ready, o_tvalid;
   logic          i_tready = 1'b0;
   logic [511:0]  o_tdata;
   logic [261:0]  o_tuser;
   logic [1:0]    o_cpl_valid;
   logic [21:0]   o_cpl_len;
   logic [15:0]   o_cpl_tag;
   logic          o_ovf;

   pcie_rx_bridge_ptile #(.RL(RL), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .avl_clk(clk), .avl_rst(rst),
      .avl_rx_valid(i_valid), .avl_rx_sop(i_sop), .avl_rx_eop(i_eop),
      .avl_rx_hdr(i_hdr), .avl_rx_data(i_data), .avl_rx_ready(o_ready),
      .axis_rx_tvalid(o_tvalid), .axis_rx_tready(i_tready),
      .axis_rx_tdata(o_tdata), .axis_rx_tuser(o_tuser),
      .rx_cpl_valid(o_cpl_valid), .rx_cpl_length(o_cpl_len),
      .rx_cpl_tag(o_cpl_tag), .rx_overflow(o_ovf));

   always #5 clk = ~clk;

   typedef struct {
      logic [511:0] d;
      logic [261:0] u;
   } beat_t;

   beat_t       q[$];
   logic        m_ready, m_ovf;
   logic [1:0]  m_cpl_v;
   logic [21:0] m_cpl_len;
   logic [15:0] m_cpl_tag;
   int          n_chk = 0, n_pass = 0;
   int          n_pop = 0;

   task automatic chk(string tag, logic [799:0] obs, logic [799:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // kind: 0 CplD, 1 Cpl (no data), 2 MWr, other random fmt/type
   function automatic logic [127:0] mkhdr(int kind, logic [9:0] len, logic [7:0] tag);
      logic [127:0] h;
      h = {$urandom, $urandom, $urandom, $urandom};
      case (kind)
         0: h[31:24] = {3'b010, 5'b01010};
         1: h[31:24] = {3'b000, 5'b01010};
         2: h[31:24] = {3'b011, 5'b00000};
         default: ;
      endcase
      h[9:0]   = len;
      h[79:72] = tag;
      return h;
   endfunction

   // Reference model: a bounded queue of DEPTH beats with head-of-queue output.
   task automatic model_edge();
      logic  do_pop, full;
      beat_t b;
      do_pop = (q.size() > 0) && i_tready;
      full   = (q.size() == DEPTH);
      for (int c = 0; c < 2; c++) begin
         logic [127:0] h;
         h = i_hdr[c*128 +: 128];
         m_cpl_v[c] = i_valid[c] && i_sop[c] && h[31:29] == 3'b010 && h[28:24] == 5'b01010;
         if (m_cpl_v[c]) begin
            m_cpl_len[c*11 +: 11] = (h[9:0] == 0) ? 11'd1024 : 11'(h[9:0]);
            m_cpl_tag[c*8 +: 8]   = h[79:72];
         end
      end
      if (do_pop) begin
         void'(q.pop_front());
         n_pop++;
      end
      if (i_valid != 2'b00) begin
         if (full) m_ovf = 1'b1;
         else begin
            b.d = i_data;
            for (int c = 0; c < 2; c++)
               b.u[c*131 +: 131] = {i_valid[c], i_sop[c], i_eop[c], i_hdr[c*128 +: 128]};
            q.push_back(b);
         end
      end
      m_ready = (q.size() <= DEPTH - RL - 2);
   endtask

   task automatic compare();
      chk("tvalid", 800'(o_tvalid), 800'(q.size() > 0));
      if (q.size() > 0) begin
         chk("tdata", 800'(o_tdata), 800'(q[0].d));
         chk("tuser", 800'(o_tuser), 800'(q[0].u));
      end
      chk("ready", 800'(o_ready), 800'(m_ready));
      chk("overflow", 800'(o_ovf), 800'(m_ovf));
      chk("cpl_valid", 800'(o_cpl_valid), 800'(m_cpl_v));
      for (int c = 0; c < 2; c++) begin
         if (m_cpl_v[c]) begin
            chk("cpl_len", 800'(o_cpl_len[c*11 +: 11]), 800'(m_cpl_len[c*11 +: 11]));
            chk("cpl_tag", 800'(o_cpl_tag[c*8 +: 8]), 800'(m_cpl_tag[c*8 +: 8]));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic idle_in();
      i_valid = '0; i_sop = '0; i_eop = '0;
   endtask

   task automatic rnd_beat(logic [1:0] v);
      i_valid = v;
      i_sop   = 2'($urandom);
      i_eop   = 2'($urandom);
      i_data  = rnd512();
      for (int c = 0; c < 2; c++)
         i_hdr[c*128 +: 128] = mkhdr($urandom_range(0, 3), 10'($urandom), 8'($urandom));
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_ready"},  800'(o_ready), 800'(0));
      chk({tag, "_tvalid"}, 800'(o_tvalid), 800'(0));
      chk({tag, "_tdata"},  800'(o_tdata), 800'(0));
      chk({tag, "_tuser"},  800'(o_tuser), 800'(0));
      chk({tag, "_cplv"},   800'(o_cpl_valid), 800'(0));
      chk({tag, "_cpll"},   800'(o_cpl_len), 800'(0));
      chk({tag, "_cplt"},   800'(o_cpl_tag), 800'(0));
      chk({tag, "_ovf"},    800'(o_ovf), 800'(0));
   endtask

   task automatic do_reset(string tag);
      idle_in();
      rst = 1'b1;
      #2;
      q.delete();
      m_ready = 0; m_ovf = 0; m_cpl_v = 0; m_cpl_len = 0; m_cpl_tag = 0;
      check_all_zero(tag);
      @(posedge clk);
      #1;
      check_all_zero(tag);
      rst = 1'b0;
   endtask

   initial begin
      int sent, pops0;
      logic [511:0] pat;
      m_ready = 0; m_ovf = 0; m_cpl_v = 0; m_cpl_len = 0; m_cpl_tag = 0;
      #3;
      do_reset("rst0");
      step();
      chk("ready_after_rst", 800'(o_ready), 800'(1));

      // Single beat with tready high: exactly one cycle of tvalid.
      i_tready = 1'b1;
      for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hA5A5A5A5;
      i_valid = 2'b01; i_sop = 2'b01; i_eop = 2'b01; i_data = pat;
      i_hdr = {128'd0, mkhdr(2, 10'd1, 8'd0)};
      step();
      chk("single_data", 800'(o_tdata), 800'(pat));
      idle_in();
      step();
      chk("single_gone", 800'(o_tvalid), 800'(0));

      // Backpressure: ready falls at 12, RL more beats still stored.
      i_tready = 1'b0;
      sent = 0;
      for (int i = 0; i < 20 && o_ready; i++) begin
         rnd_beat(2'b11);
         step();
         sent++;
      end
      chk("bp_fall_at", 800'(sent), 800'(12));
      for (int i = 0; i < RL; i++) begin
         rnd_beat(2'b01);
         step();
      end
      idle_in();
      step();
      chk("bp_no_ovf", 800'(o_ovf), 800'(0));
      i_tready = 1'b1;
      pops0 = n_pop;
      for (int i = 0; i < 20; i++) step();
      chk("bp_drained", 800'(n_pop - pops0), 800'(15));

      // Dual-channel CplD in one cycle.
      i_valid = 2'b11; i_sop = 2'b11; i_eop = 2'b11; i_data = rnd512();
      i_hdr = {mkhdr(0, 10'h000, 8'h3F), mkhdr(0, 10'h004, 8'h12)};
      step();
      chk("dual_v", 800'(o_cpl_valid), 800'(2'b11));
      chk("dual_len", 800'(o_cpl_len), 800'({11'd1024, 11'd4}));
      chk("dual_tag", 800'(o_cpl_tag), 800'({8'h3F, 8'h12}));
      idle_in();
      step();
      chk("dual_pulse", 800'(o_cpl_valid), 800'(0));

      // MWr on ch0, Cpl without data on ch1: no tap, beat still passes.
      i_valid = 2'b11; i_sop = 2'b11; i_eop = 2'b11; i_data = rnd512();
      i_hdr = {mkhdr(1, 10'h010, 8'h01), mkhdr(2, 10'h010, 8'h02)};
      step();
      chk("nocpl_v", 800'(o_cpl_valid), 800'(0));
      chk("nocpl_pass", 800'(o_tvalid), 800'(1));
      idle_in();
      step();

      // Random compliant traffic.
      for (int i = 0; i < 1500; i++) begin
         i_tready = ($urandom_range(0, 3) != 0);
         if (o_ready && $urandom_range(0, 2) != 0) rnd_beat(2'($urandom));
         else idle_in();
         step();
      end
      idle_in();
      i_tready = 1'b1;
      for (int i = 0; i < 20; i++) step();

      // Overflow: 17 pushes ignoring ready, the last one a CplD that still taps.
      i_tready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rnd_beat(2'b01);
         if (i == 16) begin
            i_sop = 2'b01;
            i_hdr[127:0] = mkhdr(0, 10'h020, 8'h77);
         end
         step();
      end
      idle_in();
      step();
      chk("ovf_set", 800'(o_ovf), 800'(1));
      i_tready = 1'b1;
      pops0 = n_pop;
      for (int i = 0; i < 20; i++) step();
      chk("ovf_drained", 800'(n_pop - pops0), 800'(16));
      chk("ovf_sticky", 800'(o_ovf), 800'(1));

      // Reset with 5 beats queued.
      i_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rnd_beat(2'b10);
         step();
      end
      do_reset("rst1");
      i_tready = 1'b1;
      for (int i = 0; i < 5; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule
